lab1_imul_mul_arbiter: RTL and testbench

LAB1_IMUL_MUL_ARBITER -- requirements
Module: lab1_imul_MulArbiter

---
 rtl/lab1_imul_mul_arbiter.sv | 122 ++++++++++++
 tb/tb_lab1_imul_mul_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_mul_arbiter.sv
// Two-requester front end sharing one 32-bit multiplier, one transaction in flight (IDLE/ISSUE/WAIT/RESP).
// Define LAB1_IMUL_MUL_ARBITER_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module lab1_imul_mul_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [63:0] req0_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [63:0] req1_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [31:0] resp0_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [31:0] resp1_msg,
    output logic        mul_istream_val,
    input  logic        mul_istream_rdy,
    output logic [63:0] mul_istream_msg,
    input  logic        mul_ostream_val,
    output logic        mul_ostream_rdy,
    input  logic [31:0] mul_ostream_msg
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [63:0] opnd_q, opnd_d;
    logic [31:0] result_q, result_d;
    logic        grant;
    logic        live;
    logic        accept;

    // Every handshake output is forced low while reset is held, whatever state is still registered.
    assign live = !reset;

`ifdef LAB1_IMUL_MUL_ARBITER_FIXED_PRIO_EN
    assign grant = !req0_val;
`else
    logic prio_q, prio_d;

    assign grant = (req0_val && req1_val) ? prio_q : req1_val;

    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            prio_d = !grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_comb begin
        req0_rdy        = live && (state_q == ST_IDLE) && (req0_val || req1_val) && !grant;
        req1_rdy        = live && (state_q == ST_IDLE) && (req0_val || req1_val) && grant;
        mul_istream_val = live && (state_q == ST_ISSUE);
        mul_istream_msg = mul_istream_val ? opnd_q : 64'h0;
        mul_ostream_rdy = live && (state_q == ST_WAIT);
        resp0_val       = live && (state_q == ST_RESP) && !owner_q;
        resp1_val       = live && (state_q == ST_RESP) && owner_q;
        resp0_msg       = resp0_val ? result_q : 32'h0;
        resp1_msg       = resp1_val ? result_q : 32'h0;
    end

    assign accept = (req0_val && req0_rdy) || (req1_val && req1_rdy);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    owner_d = grant;
                    opnd_d  = grant ? req1_msg : req0_msg;
                end
            end
            ST_ISSUE: begin
                if (mul_istream_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_ostream_val) begin
                    result_d = mul_ostream_msg;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                // Returning to IDLE here means no new request can be taken in this same cycle.
                if (owner_q ? resp1_rdy : resp0_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            opnd_q   <= 64'h0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// Bench for lab1_imul_mul_arbiter: IDLE vector table, directed sequences, then randomized traffic
// against a transaction-level model (per-requester queues, one-in-flight, round-robin tie break).
module tb_lab1_imul_mul_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [63:0] req0_msg, req1_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [31:0] resp0_msg, resp1_msg;
    logic        mul_istream_val, mul_istream_rdy, mul_ostream_val, mul_ostream_rdy;
    logic [63:0] mul_istream_msg;
    logic [31:0] mul_ostream_msg;

    lab1_imul_mul_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .mul_istream_val(mul_istream_val), .mul_istream_rdy(mul_istream_rdy),
        .mul_istream_msg(mul_istream_msg),
        .mul_ostream_val(mul_ostream_val), .mul_ostream_rdy(mul_ostream_rdy),
        .mul_ostream_msg(mul_ostream_msg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] q0[$], q1[$];
    bit          busy, own, ptr;
    logic [63:0] cur_op;
    int          grant_log[$];
    int          resp_port_log[$];
    logic [31:0] resp_data_log[$];
    logic [31:0] mq_v[$];
    int          mq_t[$];
    int          cyc = 0;
    int          mul_rdy_pct, resp_rdy_pct, lat_min, lat_max;
    bit          prev_rv0, prev_rr0, prev_rv1, prev_rr1;
    bit          saw_wait, resp1_seen, trace_en;

    typedef struct {
        logic rst, v0, v1, e0, e1;
    } tv_t;
    tv_t tv[5];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] prod(input logic [63:0] m);
        logic [31:0] a, b;
        a = m[63:32];
        b = m[31:0];
        return a * b;
    endfunction

    function automatic logic [159:0] outs();
        return {26'h0, req0_rdy, req1_rdy, resp0_val, resp1_val, mul_istream_val, mul_ostream_rdy,
                resp0_msg, resp1_msg, mul_istream_msg};
    endfunction

    function automatic string trace_line();
        string st;
        case (int'(dut.state_q))
            0: st = "I";
            1: st = "S";
            2: st = "W";
            default: st = "R";
        endcase
        return $sformatf("%0b%0b:%h %0b%0b:%h | %s%0d | %0b%0b:%h %0b%0b:%h",
                         req0_val, req0_rdy, req0_msg, req1_val, req1_rdy, req1_msg, st, dut.owner_q,
                         resp0_val, resp0_rdy, resp0_msg, resp1_val, resp1_rdy, resp1_msg);
    endfunction

    task automatic knobs(input int mr, input int rr, input int lmin, input int lmax);
        mul_rdy_pct = mr; resp_rdy_pct = rr; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic drive();
        req0_val = (q0.size() != 0);
        req0_msg = (q0.size() != 0) ? q0[0] : 64'h0;
        req1_val = (q1.size() != 0);
        req1_msg = (q1.size() != 0) ? q1[0] : 64'h0;
        mul_istream_rdy = ($urandom_range(99) < mul_rdy_pct);
        resp0_rdy = ($urandom_range(99) < resp_rdy_pct);
        resp1_rdy = ($urandom_range(99) < resp_rdy_pct);
        mul_ostream_val = (mq_v.size() != 0) && (mq_t[0] <= cyc);
        mul_ostream_msg = mul_ostream_val ? mq_v[0] : 32'h0;
    endtask

    task automatic observe();
        bit          g, any;
        logic [31:0] ep, junk_v;
        int          junk_t;
        any = req0_val || req1_val;
`ifdef LAB1_IMUL_MUL_ARBITER_FIXED_PRIO_EN
        g = !req0_val;
`else
        g = (req0_val && req1_val) ? ptr : req1_val;
`endif
        chk("req0_rdy", req0_rdy, !busy && any && !g);
        chk("req1_rdy", req1_rdy, !busy && any && g);
        ep = prod(cur_op);
        if (mul_istream_val) begin
            chk("mul_istream_busy", busy, 1);
            chk("mul_istream_msg", mul_istream_msg, cur_op);
        end
        if (resp0_val) begin
            chk("resp0_owner", busy && !own, 1);
            chk("resp0_msg", resp0_msg, ep);
        end else chk("resp0_msg_idle", resp0_msg, 0);
        if (resp1_val) begin
            resp1_seen = 1;
            chk("resp1_owner", busy && own, 1);
            chk("resp1_msg", resp1_msg, ep);
        end else chk("resp1_msg_idle", resp1_msg, 0);
        if (prev_rv0 && !prev_rr0) chk("resp0_hold", resp0_val, 1);
        if (prev_rv1 && !prev_rr1) chk("resp1_hold", resp1_val, 1);
        if (trace_en) $display("%s", trace_line());

        if (req0_val && req0_rdy) begin
            grant_log.push_back(0); cur_op = q0.pop_front(); busy = 1; own = 0; ptr = 1;
        end else if (req1_val && req1_rdy) begin
            grant_log.push_back(1); cur_op = q1.pop_front(); busy = 1; own = 1; ptr = 0;
        end
        if (mul_istream_val && mul_istream_rdy) begin
            mq_v.push_back(prod(mul_istream_msg));
            mq_t.push_back(cyc + 1 + int'($urandom_range(lat_max, lat_min)));
        end
        if (mul_ostream_val && mul_ostream_rdy) begin
            junk_v = mq_v.pop_front();
            junk_t = mq_t.pop_front();
        end
        if (resp0_val && resp0_rdy) begin
            resp_port_log.push_back(0); resp_data_log.push_back(resp0_msg); busy = 0;
        end
        if (resp1_val && resp1_rdy) begin
            resp_port_log.push_back(1); resp_data_log.push_back(resp1_msg); busy = 0;
        end
        if (mul_ostream_rdy) saw_wait = 1;
        prev_rv0 = resp0_val; prev_rr0 = resp0_rdy;
        prev_rv1 = resp1_val; prev_rr1 = resp1_rdy;
        cyc++;
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk(name, {q0.size() != 0, q1.size() != 0, busy}, 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1; req0_val = 0; req1_val = 0; req0_msg = 0; req1_msg = 0;
        resp0_rdy = 0; resp1_rdy = 0; mul_istream_rdy = 0; mul_ostream_val = 0; mul_ostream_msg = 0;
        repeat (n) begin
            @(negedge clk);
            chk("reset_outputs", outs(), 0);
            @(posedge clk);
            #1;
        end
        reset = 0;
        q0.delete(); q1.delete(); mq_v.delete(); mq_t.delete();
        grant_log.delete(); resp_port_log.delete(); resp_data_log.delete();
        busy = 0; own = 0; ptr = 0; cur_op = 0;
        prev_rv0 = 0; prev_rr0 = 0; prev_rv1 = 0; prev_rr1 = 0;
        saw_wait = 0; resp1_seen = 0;
    endtask

    function automatic logic [63:0] rand_op();
        logic [31:0] a, b;
        b = $urandom;
        case ($urandom_range(3))
            0: a = $urandom;
            1: a = 32'hFFFF_FFFF;
            2: a = 32'h0;
            default: a = $urandom_range(15);
        endcase
        return {a, b};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_port[3];
        logic [31:0] exp_data[3];
        int          pushed, n;

        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        trace_en = 0;
        knobs(100, 100, 0, 0);
        @(posedge clk);
        #1;
        do_reset(2);

        // IDLE combinational grant table, no clock edge sees a request
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset = tv[i].rst; req0_val = tv[i].v0; req1_val = tv[i].v1;
            req0_msg = 64'h1; req1_msg = 64'h2;
            #1;
            chk($sformatf("tv%0d_req0_rdy", i), req0_rdy, tv[i].e0);
            chk($sformatf("tv%0d_req1_rdy", i), req1_rdy, tv[i].e1);
            chk($sformatf("tv%0d_other", i),
                {resp0_val, resp1_val, mul_istream_val, mul_ostream_rdy, resp0_msg, resp1_msg, mul_istream_msg}, 0);
            #1;
            reset = 0; req0_val = 0; req1_val = 0;
        end
        @(posedge clk);
        #1;

        // Single requester, 3*4
        do_reset(2);
        knobs(100, 100, 0, 0);
        trace_en = 1;
        q0.push_back({32'd3, 32'd4});
        run_until_idle("A_drain", 50);
        trace_en = 0;
        repeat (3) step();
        chk("A_nresp", resp_port_log.size(), 1);
        if (resp_port_log.size() >= 1) begin
            chk("A_port", resp_port_log[0], 0);
            chk("A_data", resp_data_log[0], 32'd12);
        end
        chk("A_resp1_never", resp1_seen, 0);

        // Both valid after reset, requester 0 re-asserts
        do_reset(2);
        q0.push_back({32'd2, 32'd5});
        q0.push_back({32'd3, 32'd3});
        q1.push_back({32'd6, 32'd7});
`ifdef LAB1_IMUL_MUL_ARBITER_FIXED_PRIO_EN
        exp_port = '{0, 0, 1};
        exp_data = '{32'd10, 32'd9, 32'd42};
`else
        exp_port = '{0, 1, 0};
        exp_data = '{32'd10, 32'd42, 32'd9};
`endif
        run_until_idle("B_drain", 100);
        chk("B_nresp", resp_port_log.size(), 3);
        for (int i = 0; i < 3 && i < resp_port_log.size(); i++) begin
            chk($sformatf("B_port%0d", i), resp_port_log[i], exp_port[i]);
            chk($sformatf("B_data%0d", i), resp_data_log[i], exp_data[i]);
        end

        // Continuous contention, four requests each
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            q0.push_back({32'(i + 1), 32'd10});
            q1.push_back({32'(i + 1), 32'd20});
        end
        run_until_idle("C_drain", 200);
        chk("C_ngrant", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef LAB1_IMUL_MUL_ARBITER_FIXED_PRIO_EN
            chk($sformatf("C_grant%0d", i), grant_log[i], (i < 4) ? 0 : 1);
`else
            chk($sformatf("C_grant%0d", i), grant_log[i], i % 2);
`endif
        end

        // Stalls on both multiplier input and response side
        do_reset(2);
        knobs(50, 30, 0, 4);
        q0.push_back({32'hFFFF_FFFF, 32'd2});
        run_until_idle("D_drain", 300);
        chk("D_nresp", resp_port_log.size(), 1);
        if (resp_data_log.size() >= 1) chk("D_data", resp_data_log[0], 32'hFFFF_FFFE);

        // Reset while waiting on the multiplier
        do_reset(2);
        knobs(100, 100, 30, 30);
        q0.push_back({32'd5, 32'd6});
        for (int i = 0; i < 10 && !saw_wait; i++) step();
        chk("E_reach_wait", saw_wait, 1);
        repeat (2) step();
        do_reset(1);
        knobs(100, 100, 0, 0);
        repeat (6) step();
        chk("E_no_resp", resp_port_log.size(), 0);
        q1.push_back({32'd0, 32'd9});
        run_until_idle("E_drain", 50);
        chk("E_nresp", resp_port_log.size(), 1);
        if (resp_port_log.size() >= 1) begin
            chk("E_port", resp_port_log[0], 1);
            chk("E_data", resp_data_log[0], 32'd0);
        end

        // Randomized traffic
        do_reset(2);
        knobs(70, 60, 0, 3);
        pushed = 0;
        n = 0;
        while ((pushed < 40 || q0.size() != 0 || q1.size() != 0 || busy) && n < 3000) begin
            if (pushed < 40 && $urandom_range(99) < 25) begin q0.push_back(rand_op()); pushed++; end
            if (pushed < 40 && $urandom_range(99) < 25) begin q1.push_back(rand_op()); pushed++; end
            step();
            n++;
        end
        chk("R_drain", {pushed != 40, q0.size() != 0, q1.size() != 0, busy}, 0);
        chk("R_nresp", resp_port_log.size(), 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
